mr_wb_arb: RTL and testbench
============================

Name: mr_wb_arb

Overview:
- Writeback arbiter between the two result producers of the core and the single register-file write port in decode.
- Producer A is the normal ALU/memory pipe. Producer B is the CSR unit's return path.
- Each producer gets a small FIFO. Heads are arbitrated round-robin (or fixed-priority) onto one write stream per cycle.
- The block also maintains the retired-instruction count and per-cycle retire strobe.

Parameters:
- DEPTH, 2: entries per source FIFO; power of two, >= 2.
- XLEN, 32: data width.
- CNT_W, 64: width of the retired-instruction counter.
- PRIO_B, 0: 0 = round-robin; 1 = source B always wins when both sources are non-empty.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  pipe result valid
- a_ready  out  1  pipe FIFO A not full
- a_reg  in  5  destination register (0 = no register write, still retires)
- a_val  in  XLEN  result data
- b_valid  in  1  CSR return valid
- b_ready  out  1  CSR FIFO B not full
- b_reg  in  5  CSR destination register
- b_val  in  XLEN  CSR read data
- wr_valid  out  1  register-file write / retire this cycle
- wr_reg  out  5  write destination
- wr_val  out  XLEN  write data
- wr_src  out  1  0 = from A, 1 = from B
- insts_ret  out  3  retires this cycle (0 or 1, zero-extended)
- ret_cnt  out  CNT_W  total retired instructions
- idle  out  1  both FIFOs empty

Behaviour:
- Reset (rst low, asynchronous): FIFO pointers cleared, both FIFOs empty, all queued entries dropped. last_grant = B, so A wins the first contention. ret_cnt = 0. Deassertion is synchronous to clk.
- Output values while in reset: a_ready = b_ready = 0, wr_valid = 0, wr_reg = 0, wr_val = 0, wr_src = 0, insts_ret = 0, idle = 1.
- FIFOs: one per source; DEPTH entries of {reg, val}.
  - Read/write pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.
  - x_ready = !full_x, from registered state only; it does not look at a same-cycle dequeue.
  - Enqueue on the rising edge where x_valid & x_ready.
  - Producers hold valid and payload stable until accepted; a simulation-only assertion checks this.
- Full FIFO: ready is low even in a cycle where that FIFO dequeues. Ready rises the cycle after the dequeue.
- Grant (combinational, from FIFO heads):
  - Only one FIFO non-empty: grant it.
  - Both non-empty, PRIO_B=0: grant the source not equal to last_grant.
  - Both non-empty, PRIO_B=1: grant B.
  - Neither non-empty: no grant; wr_valid = 0; wr_reg, wr_val, wr_src driven to 0.
- Dequeue: the granted head is dequeued on the same rising edge; last_grant is updated only on a grant.
- wr_valid, wr_reg, wr_val, wr_src are driven combinationally from the granted head.
  - Latency: an entry accepted on edge k is presented in cycle k+1 at the earliest.
  - No bypass from input to output.
- Fairness: under continuous contention with PRIO_B=0, grants strictly alternate, so waiting is bounded to 1 cycle. PRIO_B=1 may starve A; this is accepted.
- Order within a source is FIFO. No ordering is guaranteed across sources; decode's destination-hazard check prevents cross-source WAW.
- insts_ret = {2'b0, wr_valid}.
- ret_cnt increments by 1 on every edge where wr_valid = 1, including wr_reg = 0, and wraps to 0 past 2^CNT_W - 1.
- idle = empty_A & empty_B, from registered state.
- Simultaneous enqueue and dequeue on the same non-full, non-empty FIFO: occupancy unchanged; both pointers advance.
- Empty FIFO with enqueue: the entry is not visible until the next cycle.
- Reset asserted mid-operation: outputs go to their reset values immediately, without waiting for clk.

Test Plan:
- Single A write: a_valid=1, a_reg=5, a_val=0xDEADBEEF for one accepted cycle. Required: wr_valid=1, wr_reg=5, wr_val=0xDEADBEEF, wr_src=0 exactly one cycle later; ret_cnt goes 0 -> 1.
- Contention, PRIO_B=0: preload A with regs {1,2,3} and B with regs {10,11}, producers then idle. Required: wr_reg sequence 1,10,2,11,3 on consecutive cycles; ret_cnt = 5; then idle = 1.
- Contention, PRIO_B=1: same preload. Required: wr_reg sequence 10,11,1,2,3.
- Full boundary, DEPTH=2: push 3 entries into A while B is active and granted first. Required: a_ready=0 after the 2nd accept; the 3rd entry is accepted only in the cycle after the first A dequeue; no entry is lost or duplicated.
- x0 retire and counter wrap: CNT_W=4, preload ret_cnt to 15 with 15 writes, then one a_reg=0 write. Required: wr_valid=1, insts_ret=1, ret_cnt wraps to 0.
- Async reset mid-stream: assert rst low between clock edges with 2 entries queued in each FIFO. Required: wr_valid=0, a_ready=b_ready=0, idle=1 immediately. After release, the first contention grants A, and none of the dropped entries ever appear on wr_*.

Source files
------------

// File: rtl/mr_wb_arb_if.sv
// Writeback arbiter bus: two producer request channels, the register-file
// write stream and retire status.
interface mr_wb_arb_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             a_valid;
  logic             a_ready;
  logic [4:0]       a_reg;
  logic [XLEN-1:0]  a_val;
  logic             b_valid;
  logic             b_ready;
  logic [4:0]       b_reg;
  logic [XLEN-1:0]  b_val;
  logic             wr_valid;
  logic [4:0]       wr_reg;
  logic [XLEN-1:0]  wr_val;
  logic             wr_src;
  logic [2:0]       insts_ret;
  logic [CNT_W-1:0] ret_cnt;
  logic             idle;

  modport master (
    output a_valid, a_reg, a_val, b_valid, b_reg, b_val,
    input  a_ready, b_ready, wr_valid, wr_reg, wr_val, wr_src,
           insts_ret, ret_cnt, idle
  );

  modport slave (
    input  a_valid, a_reg, a_val, b_valid, b_reg, b_val,
    output a_ready, b_ready, wr_valid, wr_reg, wr_val, wr_src,
           insts_ret, ret_cnt, idle
  );
endinterface

// File: rtl/mr_wb_arb.sv
// Writeback arbiter: per-source FIFOs (index 0 = pipe A, 1 = CSR B) merged
// onto the single register-file write port, plus the retired-instruction count.
module mr_wb_arb #(
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 64,
  parameter int PRIO_B = 0
) (
  input logic        clk,
  input logic        rst,
  mr_wb_arb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [PW-1:0]    r_wptr    [2];
  logic [PW-1:0]    r_rptr    [2];
  logic [4:0]       r_reg_mem [2][DEPTH];
  logic [XLEN-1:0]  r_val_mem [2][DEPTH];
  logic             r_last;
  logic             r_live;
  logic [CNT_W-1:0] r_ret_cnt;

  logic [1:0]       w_in_vld;
  logic [1:0]       w_empty;
  logic [1:0]       w_full;
  logic [1:0]       w_ready;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [4:0]       w_in_reg   [2];
  logic [XLEN-1:0]  w_in_val   [2];
  logic [4:0]       w_head_reg [2];
  logic [XLEN-1:0]  w_head_val [2];
  logic             w_gnt_vld;
  logic             w_gnt_src;

  assign w_in_vld    = {bus.b_valid, bus.a_valid};
  assign w_in_reg[0] = bus.a_reg;
  assign w_in_reg[1] = bus.b_reg;
  assign w_in_val[0] = bus.a_val;
  assign w_in_val[1] = bus.b_val;

  // r_live holds ready low until the first edge after reset release.
  for (genvar s = 0; s < 2; s++) begin : g_src
    assign w_empty[s]    = (r_wptr[s] == r_rptr[s]);
    assign w_full[s]     = (r_wptr[s][AW] != r_rptr[s][AW]) &&
                           (r_wptr[s][AW-1:0] == r_rptr[s][AW-1:0]);
    assign w_ready[s]    = r_live & ~w_full[s];
    assign w_push[s]     = w_in_vld[s] & w_ready[s];
    assign w_pop[s]      = w_gnt_vld & (w_gnt_src == 1'(s));
    assign w_head_reg[s] = r_reg_mem[s][r_rptr[s][AW-1:0]];
    assign w_head_val[s] = r_val_mem[s][r_rptr[s][AW-1:0]];
  end

  // Grant selection from the FIFO heads
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_src = 1'b0;
    case ({~w_empty[1], ~w_empty[0]})
      2'b01: begin
        w_gnt_vld = 1'b1;
        w_gnt_src = 1'b0;
      end
      2'b10: begin
        w_gnt_vld = 1'b1;
        w_gnt_src = 1'b1;
      end
      2'b11: begin
        w_gnt_vld = 1'b1;
        if (PRIO_B != 0) begin
          w_gnt_src = 1'b1;
        end else begin
          w_gnt_src = ~r_last;
        end
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_src = 1'b0;
      end
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        r_wptr[s] <= {PW{1'b0}};
        r_rptr[s] <= {PW{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
          r_reg_mem[s][e] <= 5'd0;
          r_val_mem[s][e] <= {XLEN{1'b0}};
        end
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) begin
          r_reg_mem[s][r_wptr[s][AW-1:0]] <= w_in_reg[s];
          r_val_mem[s][r_wptr[s][AW-1:0]] <= w_in_val[s];
          r_wptr[s]                       <= r_wptr[s] + PTR_ONE;
        end
        if (w_pop[s]) begin
          r_rptr[s] <= r_rptr[s] + PTR_ONE;
        end
      end
    end
  end

  // Round-robin history, reset-release gate and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= 1'b1;
      r_live    <= 1'b0;
      r_ret_cnt <= {CNT_W{1'b0}};
    end else begin
      r_live <= 1'b1;
      if (w_gnt_vld) begin
        r_last    <= w_gnt_src;
        r_ret_cnt <= r_ret_cnt + CNT_ONE;
      end
    end
  end

  assign bus.a_ready   = w_ready[0];
  assign bus.b_ready   = w_ready[1];
  assign bus.wr_valid  = w_gnt_vld;
  assign bus.wr_src    = w_gnt_src;
  assign bus.wr_reg    = w_gnt_vld ? w_head_reg[w_gnt_src] : 5'd0;
  assign bus.wr_val    = w_gnt_vld ? w_head_val[w_gnt_src] : {XLEN{1'b0}};
  assign bus.insts_ret = {2'b00, w_gnt_vld};
  assign bus.ret_cnt   = r_ret_cnt;
  assign bus.idle      = w_empty[0] & w_empty[1];

  mr_wb_arb_chk #(.XLEN(XLEN)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .a_valid (bus.a_valid),
    .a_ready (w_ready[0]),
    .a_reg   (bus.a_reg),
    .a_val   (bus.a_val),
    .b_valid (bus.b_valid),
    .b_ready (w_ready[1]),
    .b_reg   (bus.b_reg),
    .b_val   (bus.b_val)
  );
endmodule

// Producer-side protocol checks: a pending request must stay put until taken.
module mr_wb_arb_chk #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst,
  input logic            a_valid,
  input logic            a_ready,
  input logic [4:0]      a_reg,
  input logic [XLEN-1:0] a_val,
  input logic            b_valid,
  input logic            b_ready,
  input logic [4:0]      b_reg,
  input logic [XLEN-1:0] b_val
);
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (a_valid && !a_ready) |=> (a_valid && $stable(a_reg) && $stable(a_val)))
    else $error("mr_wb_arb: producer A changed its request before acceptance");

  b_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (b_valid && !b_ready) |=> (b_valid && $stable(b_reg) && $stable(b_val)))
    else $error("mr_wb_arb: producer B changed its request before acceptance");
endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: dut0 is round-robin with a 4-bit counter,
// dut1 is B-priority with the full 64-bit counter; both use DEPTH=2.
module tb_mr_wb_arb;
  typedef struct {
    int          cyc;
    logic        src;
    logic [4:0]  rg;
    logic [31:0] val;
  } wr_t;

  typedef struct {
    int          src;
    logic [4:0]  rg;
    logic [31:0] val;
    logic [4:0]  e_reg;
    logic [31:0] e_val;
    logic        e_src;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic        s_vld [2][2];
  logic [4:0]  s_reg [2][2];
  logic [31:0] s_val [2][2];
  int          last_acc  [2][2];
  int          last_wait [2][2];
  wr_t         mon0 [$];
  wr_t         mon1 [$];

  mr_wb_arb_if #(.XLEN(32), .CNT_W(4))  if0 ();
  mr_wb_arb_if #(.XLEN(32), .CNT_W(64)) if1 ();

  assign if0.a_valid = s_vld[0][0];
  assign if0.a_reg   = s_reg[0][0];
  assign if0.a_val   = s_val[0][0];
  assign if0.b_valid = s_vld[0][1];
  assign if0.b_reg   = s_reg[0][1];
  assign if0.b_val   = s_val[0][1];
  assign if1.a_valid = s_vld[1][0];
  assign if1.a_reg   = s_reg[1][0];
  assign if1.a_val   = s_val[1][0];
  assign if1.b_valid = s_vld[1][1];
  assign if1.b_reg   = s_reg[1][1];
  assign if1.b_val   = s_val[1][1];

  mr_wb_arb #(.DEPTH(2), .XLEN(32), .CNT_W(4), .PRIO_B(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  mr_wb_arb #(.DEPTH(2), .XLEN(32), .CNT_W(64), .PRIO_B(1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  function automatic wr_t mk(input int c, input logic s, input logic [4:0] r, input logic [31:0] v);
    wr_t e;
    e.cyc = c;
    e.src = s;
    e.rg  = r;
    e.val = v;
    return e;
  endfunction

  // Record every write-port beat, sampled mid-cycle
  always @(negedge clk) begin
    if (if0.wr_valid) mon0.push_back(mk(cyc, if0.wr_src, if0.wr_reg, if0.wr_val));
    if (if1.wr_valid) mon1.push_back(mk(cyc, if1.wr_src, if1.wr_reg, if1.wr_val));
  end

  function automatic logic [31:0] vfn(input int r, input int s);
    return ((s != 0) ? 32'hB000_0000 : 32'hA000_0000) | 32'(r);
  endfunction

  function automatic logic rdy(input int d, input int s);
    if (d == 0) return (s == 0) ? if0.a_ready : if0.b_ready;
    else        return (s == 0) ? if1.a_ready : if1.b_ready;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one entry (called at a falling edge) and hold it until accepted
  task automatic push(input int d, input int s, input logic [4:0] r, input logic [31:0] v);
    int w;
    w = 0;
    s_vld[d][s] = 1'b1;
    s_reg[d][s] = r;
    s_val[d][s] = v;
    while (!rdy(d, s) && w < 40) begin
      w++;
      @(negedge clk);
    end
    last_wait[d][s] = w;
    if (w >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout dut%0d src%0d: ready stayed 0 expected 1", d, s);
      s_vld[d][s] = 1'b0;
    end else begin
      last_acc[d][s] = cyc;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic stream(input int d, input int s, input int base, input int n);
    for (int i = 0; i < n; i++) push(d, s, 5'(base + i), vfn(base + i, s));
    s_vld[d][s] = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int d, input int n, input int er[8], input int es[8]);
    wr_t q[$];
    if (d == 0) q = mon0;
    else        q = mon1;
    chk({name, " count"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      chk({name, " reg"}, 64'(q[i].rg), 64'(er[i]));
      chk({name, " src"}, 64'(q[i].src), 64'(es[i]));
      chk({name, " val"}, 64'(q[i].val), 64'(vfn(er[i], es[i])));
      if (i > 0) chk({name, " gap"}, 64'(q[i].cyc - q[i-1].cyc), 64'd1);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " a_ready0"},  64'(if0.a_ready),   64'd0);
    chk({tag, " b_ready0"},  64'(if0.b_ready),   64'd0);
    chk({tag, " wr_valid0"}, 64'(if0.wr_valid),  64'd0);
    chk({tag, " wr_reg0"},   64'(if0.wr_reg),    64'd0);
    chk({tag, " wr_val0"},   64'(if0.wr_val),    64'd0);
    chk({tag, " wr_src0"},   64'(if0.wr_src),    64'd0);
    chk({tag, " insts0"},    64'(if0.insts_ret), 64'd0);
    chk({tag, " idle0"},     64'(if0.idle),      64'd1);
    chk({tag, " cnt0"},      64'(if0.ret_cnt),   64'd0);
    chk({tag, " a_ready1"},  64'(if1.a_ready),   64'd0);
    chk({tag, " b_ready1"},  64'(if1.b_ready),   64'd0);
    chk({tag, " wr_valid1"}, 64'(if1.wr_valid),  64'd0);
    chk({tag, " idle1"},     64'(if1.idle),      64'd1);
    chk({tag, " cnt1"},      64'(if1.ret_cnt),   64'd0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vec_t tv[5];
    int   er[8];
    int   es[8];
    int   exp_cnt;
    int   acc1;
    int   acc2;

    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) begin
        s_vld[d][s] = 1'b0;
        s_reg[d][s] = 5'd0;
        s_val[d][s] = 32'd0;
      end
    end

    tv[0] = '{0, 5'd5,  32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b0};
    tv[1] = '{1, 5'd7,  32'h1234_5678, 5'd7,  32'h1234_5678, 1'b1};
    tv[2] = '{0, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0};
    tv[3] = '{1, 5'd31, 32'h0000_0000, 5'd31, 32'h0000_0000, 1'b1};
    tv[4] = '{0, 5'd31, 32'hA5A5_5A5A, 5'd31, 32'hA5A5_5A5A, 1'b0};

    // Reset values while held in reset
    #12;
    chk_rst("por");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst a_ready0", 64'(if0.a_ready), 64'd1);
    chk("post_rst b_ready1", 64'(if1.b_ready), 64'd1);

    // Single writes: one-cycle latency, no bypass, counter steps
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      s_vld[0][tv[i].src] = 1'b1;
      s_reg[0][tv[i].src] = tv[i].rg;
      s_val[0][tv[i].src] = tv[i].val;
      chk("vec ready", 64'(rdy(0, tv[i].src)), 64'd1);
      chk("vec no_bypass", 64'(if0.wr_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      s_vld[0][tv[i].src] = 1'b0;
      chk("vec wr_valid", 64'(if0.wr_valid), 64'd1);
      chk("vec wr_reg", 64'(if0.wr_reg), 64'(tv[i].e_reg));
      chk("vec wr_val", 64'(if0.wr_val), 64'(tv[i].e_val));
      chk("vec wr_src", 64'(if0.wr_src), 64'(tv[i].e_src));
      chk("vec insts_ret", 64'(if0.insts_ret), 64'd1);
      chk("vec idle_busy", 64'(if0.idle), 64'd0);
      chk("vec cnt_before", 64'(if0.ret_cnt), 64'(exp_cnt));
      @(posedge clk);
      @(negedge clk);
      exp_cnt = (exp_cnt + 1) % 16;
      chk("vec cnt_after", 64'(if0.ret_cnt), 64'(exp_cnt));
      chk("vec drained", 64'(if0.wr_valid), 64'd0);
      chk("vec idle", 64'(if0.idle), 64'd1);
    end

    // Contention: A {1,2,3} against B {10,11} on both arbitration modes
    rst_pulse();
    mon0.delete();
    mon1.delete();
    fork
      stream(0, 0, 1, 3);
      stream(0, 1, 10, 2);
      stream(1, 0, 1, 3);
      stream(1, 1, 10, 2);
    join
    repeat (4) @(negedge clk);
    er = '{1, 10, 2, 11, 3, 0, 0, 0};
    es = '{0, 1, 0, 1, 0, 0, 0, 0};
    chk_seq("rr", 0, 5, er, es);
    er = '{10, 11, 1, 2, 3, 0, 0, 0};
    es = '{1, 1, 0, 0, 0, 0, 0, 0};
    chk_seq("prio", 1, 5, er, es);
    chk("rr cnt", 64'(if0.ret_cnt), 64'd5);
    chk("prio cnt", 64'(if1.ret_cnt), 64'd5);
    chk("rr idle", 64'(if0.idle), 64'd1);
    chk("prio idle", 64'(if1.idle), 64'd1);

    // Full boundary: last grant was A, so B wins first and A fills up
    mon0.delete();
    acc1 = 0;
    acc2 = 0;
    fork
      begin
        push(0, 0, 5'd1, vfn(1, 0));
        acc1 = last_acc[0][0];
        chk("full a1_wait", 64'(last_wait[0][0]), 64'd0);
        push(0, 0, 5'd2, vfn(2, 0));
        acc2 = last_acc[0][0];
        chk("full a2_wait", 64'(last_wait[0][0]), 64'd0);
        chk("full a2_back2back", 64'(acc2 - acc1), 64'd1);
        chk("full a_ready_low", 64'(if0.a_ready), 64'd0);
        push(0, 0, 5'd3, vfn(3, 0));
        chk("full a3_wait", 64'(last_wait[0][0]), 64'd1);
        s_vld[0][0] = 1'b0;
      end
      stream(0, 1, 10, 2);
    join
    repeat (4) @(negedge clk);
    er = '{10, 1, 11, 2, 3, 0, 0, 0};
    es = '{1, 0, 1, 0, 0, 0, 0, 0};
    chk_seq("full", 0, 5, er, es);
    if (mon0.size() >= 2)
      chk("full a3_after_deq", 64'(last_acc[0][0] - mon0[1].cyc), 64'd1);
    chk("full cnt", 64'(if0.ret_cnt), 64'd10);

    // Counter wrap on a 4-bit count with an x0 retire
    rst_pulse();
    stream(0, 0, 1, 15);
    for (int i = 0; i < 20 && !if0.idle; i++) @(negedge clk);
    chk("wrap idle", 64'(if0.idle), 64'd1);
    chk("wrap cnt15", 64'(if0.ret_cnt), 64'd15);
    s_vld[0][0] = 1'b1;
    s_reg[0][0] = 5'd0;
    s_val[0][0] = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    s_vld[0][0] = 1'b0;
    chk("wrap wr_valid", 64'(if0.wr_valid), 64'd1);
    chk("wrap wr_reg", 64'(if0.wr_reg), 64'd0);
    chk("wrap wr_val", 64'(if0.wr_val), 64'h0BAD_F00D);
    chk("wrap insts_ret", 64'(if0.insts_ret), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("wrap cnt0", 64'(if0.ret_cnt), 64'd0);

    // Asynchronous reset with entries still queued
    for (int d = 0; d < 2; d++) begin
      s_vld[d][0] = 1'b1; s_reg[d][0] = 5'd20; s_val[d][0] = 32'hBAD0_0020;
      s_vld[d][1] = 1'b1; s_reg[d][1] = 5'd24; s_val[d][1] = 32'hBAD0_0024;
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_reg[d][0] = 5'd21; s_val[d][0] = 32'hBAD0_0021;
      s_reg[d][1] = 5'd25; s_val[d][1] = 32'hBAD0_0025;
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_vld[d][0] = 1'b0;
      s_vld[d][1] = 1'b0;
    end
    chk("mid queued", 64'(if0.idle), 64'd0);
    #2;
    rst = 1'b0;
    #1;
    chk_rst("async");
    mon0.delete();
    mon1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fork
      stream(0, 0, 1, 1);
      stream(0, 1, 10, 1);
      stream(1, 0, 1, 1);
      stream(1, 1, 10, 1);
    join
    repeat (4) @(negedge clk);
    er = '{1, 10, 0, 0, 0, 0, 0, 0};
    es = '{0, 1, 0, 0, 0, 0, 0, 0};
    chk_seq("after_rst rr", 0, 2, er, es);
    er = '{10, 1, 0, 0, 0, 0, 0, 0};
    es = '{1, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("after_rst prio", 1, 2, er, es);
    chk("after_rst cnt", 64'(if0.ret_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
